lb_diverge_monitor: RTL and testbench
=====================================

# lb_diverge_monitor

- Two-copy (2-safety) load-buffer divergence checker for the sodor5 security harness.
- Sits directly downstream of the two core instances (or the two model instances). It consumes each copy's `port_lb_table_valid/addr/data` and reports whether, when, and how the copies' load-buffer state diverged.
- Observation runs over a programmed window.
- Replaces the fixed-counter assert in the top-level harness with a reusable sequential checker whose verdict can be asserted or covered.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles to wait after `start` before sampling begins (0 allowed).
- `WINDOW`, default 12: number of observed cycles (1..2^`CYC_W`).
- `CYC_W`, default 8: width of the cycle index output.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a check; accepted only in IDLE.
- `clear`  in  1  synchronous abort; return to IDLE and clear results. Wins over `start`.
- `lb_valid_a`, `lb_valid_b`  in  1  each copy's load-buffer valid.
- `lb_addr_a`, `lb_addr_b`  in  32  each copy's load-buffer address.
- `lb_data_a`, `lb_data_b`  in  32  each copy's load-buffer data.
- `regfile_a`, `regfile_b`  in  1024  each copy's flattened register file (present only with `LB_MON_REGFILE_EN`).
- `busy`  out  1  high in SETTLE or OBSERVE.
- `done`  out  1  one-cycle pulse when the window completes.
- `diverge`  out  1  sticky mismatch flag.
- `diverge_kind`  out  2  0 none, 1 valid mismatch, 2 addr mismatch, 3 data mismatch.
- `diverge_cycle`  out  `CYC_W`  observe index (0-based) of the first mismatch.
- `regfile_diverge`  out  1  sticky regfile mismatch (present only with `LB_MON_REGFILE_EN`).

## Operation
- States: IDLE, SETTLE, OBSERVE, DONE; one counter `cnt` of width `CYC_W`.
- IDLE + `start`:
  - Clear `diverge`, `diverge_kind`, `diverge_cycle` and `regfile_diverge`; set `cnt`=0.
  - Go to SETTLE, or to OBSERVE if `SETTLE_CYCLES`==0.
- SETTLE: increment `cnt` each cycle. When `cnt`==`SETTLE_CYCLES`-1, go to OBSERVE with `cnt`=0.
- OBSERVE: each cycle, compare the inputs and classify with this priority:
  - `lb_valid_a`≠`lb_valid_b` → kind 1.
  - Else both valid and addr differ → kind 2.
  - Else both valid and data differ → kind 3.
  - Both invalid → no mismatch, regardless of addr/data.
- Recording:
  - On the first mismatch only, set `diverge`=1, capture kind and `diverge_cycle`=`cnt`.
  - Later mismatches do not overwrite the captured kind or cycle.
- Window end: after the sample at `cnt`==`WINDOW`-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Result hold: results stay stable in IDLE until the next accepted `start` or `clear`.
- `start` while `busy` or in DONE: ignored, no effect.
- `clear` in any state: next state IDLE; all outputs return to their reset values.
- Simultaneous events:
  - `clear`+`start` in IDLE: `clear` wins; stay IDLE.
  - Mismatch on the same cycle as `clear`: not recorded.

## Timing
- Reset (`reset_n`=0, async): state IDLE, `cnt`=0, and every output 0 (`busy`, `done`, `diverge`, `diverge_kind`, `diverge_cycle`, `regfile_diverge`).
- `busy` rises the cycle after `start` is accepted.
- A sample is taken at the rising edge while in OBSERVE. `diverge` and its kind/cycle are visible the cycle after the sampled mismatch.
- Total latency from `start` accepted to `done` pulse: `SETTLE_CYCLES`+`WINDOW`+1 cycles.
- Reset deasserted mid-check: the monitor restarts in IDLE; no partial result survives.
- All comparisons are combinational on the inputs and registered once; no input registering beyond that.

## Configuration
- Macro: `LB_MON_REGFILE_EN`.
- Defined:
  - Adds the `regfile_a/b` inputs and the `regfile_diverge` output.
  - In OBSERVE, any sample with `regfile_a`≠`regfile_b` sets `regfile_diverge` (sticky).
  - This does not affect `diverge` or `diverge_kind`.
- Undefined: those ports and the 1024-bit comparator are absent; the rest of the behaviour is identical.

## Test plan
- Identical streams: `SETTLE_CYCLES`=2, `WINDOW`=12, both copies valid with addr 0x64, data 0xAB. Required: `done` exactly 15 cycles after `start`; `diverge`=0, `diverge_kind`=0.
- Valid skew: `lb_valid_a` rises at observe index 3, `lb_valid_b` at index 4. Required: `diverge`=1, kind 1, `diverge_cycle`=3.
- Addr then data: addr differs (0x64 vs 0x68) at index 5, data differs at index 7. Required: kind 2, cycle 5; not overwritten by the index-7 mismatch.
- Invalid don't-care: both valid=0, addr/data differ every cycle. Required: `diverge`=0 at `done`.
- Abort: `clear` at observe index 6 after a recorded mismatch. Required: IDLE next cycle, all outputs 0, no `done`. Follow with `start` during `busy`, which must be ignored.
- With `LB_MON_REGFILE_EN`: regfile bit 37 differs at index 2, lb streams equal. Required: `regfile_diverge`=1, `diverge`=0.

Source files
------------

// File: rtl/lb_diverge_monitor.sv
// lb_diverge_monitor: two-copy load-buffer divergence checker.
// After `start`, waits SETTLE_CYCLES, then compares both copies' load-buffer
// valid/addr/data for WINDOW cycles. It records the first mismatch (kind and
// observe index) in sticky registers and pulses `done` when the window ends.
// Optional feature macro: LB_MON_REGFILE_EN adds the regfile_a/b inputs and
// a sticky regfile_diverge output.
module lb_diverge_monitor #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WINDOW        = 12,
  parameter int CYC_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic             lb_valid_a,
  input  logic             lb_valid_b,
  input  logic [31:0]      lb_addr_a,
  input  logic [31:0]      lb_addr_b,
  input  logic [31:0]      lb_data_a,
  input  logic [31:0]      lb_data_b,
`ifdef LB_MON_REGFILE_EN
  input  logic [1023:0]    regfile_a,
  input  logic [1023:0]    regfile_b,
  output logic             regfile_diverge,
`endif
  output logic             busy,
  output logic             done,
  output logic             diverge,
  output logic [1:0]       diverge_kind,
  output logic [CYC_W-1:0] diverge_cycle
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    OBSERVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Mismatch classes reported on diverge_kind.
  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_ADDR  = 2'd2;
  localparam logic [1:0] K_DATA  = 2'd3;

  // Terminal counts; SETTLE_LAST is unused when SETTLE_CYCLES==0 because
  // SETTLE is skipped entirely in that case.
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [1:0]       kind_q, kind_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [1:0]       mm_kind;
`ifdef LB_MON_REGFILE_EN
  logic             rf_q, rf_d;
  logic             rf_ne;
`endif

  // Classify this cycle's inputs; valid mismatch outranks addr outranks data,
  // and addr/data are don't-care while both copies are invalid.
  always_comb begin
    mm_kind = K_NONE;
    if (lb_valid_a != lb_valid_b)                mm_kind = K_VALID;
    else if (lb_valid_a && lb_addr_a != lb_addr_b) mm_kind = K_ADDR;
    else if (lb_valid_a && lb_data_a != lb_data_b) mm_kind = K_DATA;
  end

`ifdef LB_MON_REGFILE_EN
  // Full-width regfile compare; only consulted while observing.
  assign rf_ne = (regfile_a != regfile_b);
`endif

  // Next-state, counter and sticky-result logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    kind_d  = kind_q;
    cyc_d   = cyc_q;
`ifdef LB_MON_REGFILE_EN
    rf_d    = rf_q;
`endif
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      div_d   = 1'b0;
      kind_d  = K_NONE;
      cyc_d   = '0;
`ifdef LB_MON_REGFILE_EN
      rf_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d   = '0;
            div_d   = 1'b0;
            kind_d  = K_NONE;
            cyc_d   = '0;
`ifdef LB_MON_REGFILE_EN
            rf_d    = 1'b0;
`endif
            state_d = (SETTLE_CYCLES == 0) ? OBSERVE : SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = OBSERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        OBSERVE: begin
          // Only the first mismatch is captured; later ones leave it intact.
          if (mm_kind != K_NONE && !div_q) begin
            div_d  = 1'b1;
            kind_d = mm_kind;
            cyc_d  = cnt_q;
          end
`ifdef LB_MON_REGFILE_EN
          if (rf_ne) rf_d = 1'b1;
`endif
          if (cnt_q == WIN_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      kind_q  <= K_NONE;
      cyc_q   <= '0;
`ifdef LB_MON_REGFILE_EN
      rf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      kind_q  <= kind_d;
      cyc_q   <= cyc_d;
`ifdef LB_MON_REGFILE_EN
      rf_q    <= rf_d;
`endif
    end
  end

  assign busy          = (state_q == SETTLE) || (state_q == OBSERVE);
  assign done          = (state_q == DONE);
  assign diverge       = div_q;
  assign diverge_kind  = kind_q;
  assign diverge_cycle = cyc_q;
`ifdef LB_MON_REGFILE_EN
  assign regfile_diverge = rf_q;
`endif

endmodule

// File: tb/tb_lb_diverge_monitor.sv
// Directed bench for lb_diverge_monitor at default parameters
// (SETTLE_CYCLES=2, WINDOW=12): observe index k is sampled at the 4th+k
// rising edge after start is presented, done is seen 15 cycles after start.
module tb_lb_diverge_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, clear;
  logic        lb_valid_a, lb_valid_b;
  logic [31:0] lb_addr_a, lb_addr_b, lb_data_a, lb_data_b;
  logic        busy, done, diverge;
  logic [1:0]  diverge_kind;
  logic [7:0]  diverge_cycle;
`ifdef LB_MON_REGFILE_EN
  logic [1023:0] regfile_a, regfile_b;
  logic          regfile_diverge;
  int            rf_idx;
`endif

  always #5 clk = ~clk;

  lb_diverge_monitor dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .lb_valid_a(lb_valid_a), .lb_valid_b(lb_valid_b),
    .lb_addr_a(lb_addr_a), .lb_addr_b(lb_addr_b),
    .lb_data_a(lb_data_a), .lb_data_b(lb_data_b),
`ifdef LB_MON_REGFILE_EN
    .regfile_a(regfile_a), .regfile_b(regfile_b),
    .regfile_diverge(regfile_diverge),
`endif
    .busy(busy), .done(done), .diverge(diverge),
    .diverge_kind(diverge_kind), .diverge_cycle(diverge_cycle)
  );

  int total = 0;
  int bad   = 0;

  // Per-observe-index stimulus.
  logic        va [0:11];
  logic        vb [0:11];
  logic [31:0] aa [0:11];
  logic [31:0] ab [0:11];
  logic [31:0] da [0:11];
  logic [31:0] db [0:11];
  // Per-iteration snapshots taken at the negedge.
  logic        dv [0:39];
  logic        bz [0:39];
  logic [1:0]  kd [0:39];
  logic [7:0]  cy [0:39];
  int          clr_e, start2_e, lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic v, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 12; i++) begin
      va[i] = v; vb[i] = v; aa[i] = a; ab[i] = a; da[i] = d; db[i] = d;
    end
    clr_e = -1; start2_e = -1;
`ifdef LB_MON_REGFILE_EN
    rf_idx = -1;
`endif
  endtask

  // Present start, stream the tables, stop at done or after 40 cycles.
  task automatic run(output int l);
    l = -1;
    for (int e = 0; e < 40; e++) begin
      int idx;
      @(negedge clk);
      dv[e] = diverge; bz[e] = busy; kd[e] = diverge_kind; cy[e] = diverge_cycle;
      if (e > 0 && done === 1'b1) begin
        l = e;
        break;
      end
      start = (e == 0) || (e == start2_e);
      clear = (e == clr_e);
      idx = e - 3;
      if (idx >= 0 && idx < 12) begin
        lb_valid_a = va[idx]; lb_valid_b = vb[idx];
        lb_addr_a = aa[idx]; lb_addr_b = ab[idx];
        lb_data_a = da[idx]; lb_data_b = db[idx];
      end else begin
        lb_valid_a = 1'b0; lb_valid_b = 1'b0;
        lb_addr_a = '0; lb_addr_b = '0; lb_data_a = '0; lb_data_b = '0;
      end
`ifdef LB_MON_REGFILE_EN
      regfile_b = regfile_a;
      if (idx == rf_idx) regfile_b[37] = ~regfile_a[37];
`endif
    end
    start = 1'b0; clear = 1'b0;
    lb_valid_a = 1'b0; lb_valid_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; clear = 1'b0;
    lb_valid_a = 1'b0; lb_valid_b = 1'b0;
    lb_addr_a = '0; lb_addr_b = '0; lb_data_a = '0; lb_data_b = '0;
`ifdef LB_MON_REGFILE_EN
    regfile_a = {32{32'hA5A5_5A5A}}; regfile_b = regfile_a;
`endif
    fill(1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div", diverge, 0);
    chk("rst_kind", diverge_kind, 0);
    chk("rst_cyc", diverge_cycle, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Identical streams
    fill(1'b1, 32'h64, 32'hAB);
    run(lat);
    chk("same_lat", lat, 15);
    chk("same_div", diverge, 0);
    chk("same_kind", diverge_kind, 0);
    chk("same_busy1", bz[1], 1);

    // Valid skew
    fill(1'b1, 32'h64, 32'hAB);
    for (int i = 0; i < 12; i++) begin va[i] = (i >= 3); vb[i] = (i >= 4); end
    run(lat);
    chk("skew_lat", lat, 15);
    chk("skew_div", diverge, 1);
    chk("skew_kind", diverge_kind, 1);
    chk("skew_cyc", diverge_cycle, 3);
    chk("skew_pre", dv[6], 0);
    chk("skew_post", dv[7], 1);
    repeat (3) @(negedge clk);
    chk("hold_kind", diverge_kind, 1);
    chk("hold_cyc", diverge_cycle, 3);

    // Addr then data, with a start pulse while busy
    fill(1'b1, 32'h64, 32'hAB);
    ab[5] = 32'h68; db[7] = 32'hAC; start2_e = 5;
    run(lat);
    chk("ad_lat", lat, 15);
    chk("ad_kind", diverge_kind, 2);
    chk("ad_cyc", diverge_cycle, 5);

    // Invalid don't-care
    fill(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      aa[i] = i; ab[i] = i + 100; da[i] = 32'h11; db[i] = 32'h22;
    end
    run(lat);
    chk("inv_lat", lat, 15);
    chk("inv_div", diverge, 0);
    chk("inv_kind", diverge_kind, 0);

    // Data mismatch at first and at last index
    fill(1'b1, 32'h64, 32'hAB);
    db[0] = 32'h0;
    run(lat);
    chk("d0_kind", diverge_kind, 3);
    chk("d0_cyc", diverge_cycle, 0);
    fill(1'b1, 32'h64, 32'hAB);
    db[11] = 32'h0;
    run(lat);
    chk("d11_kind", diverge_kind, 3);
    chk("d11_cyc", diverge_cycle, 11);

    // Abort: mismatch at index 2, clear at index 6
    fill(1'b1, 32'h64, 32'hAB);
    ab[2] = 32'h68; ab[6] = 32'h68; clr_e = 9;
    run(lat);
    chk("abort_nodone", lat, -1);
    chk("abort_pre", dv[9], 1);
    chk("abort_busy", bz[10], 0);
    chk("abort_div", dv[10], 0);
    chk("abort_kind", kd[10], 0);
    chk("abort_cyc", cy[10], 0);
    // clear+start together in IDLE: stays idle
    @(negedge clk); start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    chk("clrstart_busy", busy, 0);
    // start during busy ignored
    fill(1'b1, 32'h64, 32'hAB);
    start2_e = 7;
    run(lat);
    chk("ign_lat", lat, 15);
    chk("ign_div", diverge, 0);

`ifdef LB_MON_REGFILE_EN
    fill(1'b1, 32'h64, 32'hAB);
    rf_idx = 2;
    run(lat);
    chk("rf_div", regfile_diverge, 1);
    chk("rf_lbdiv", diverge, 0);
`endif

    // Async reset mid-check drops the partial result
    @(negedge clk);
    start = 1'b1; lb_valid_a = 1'b1; lb_valid_b = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_div", diverge, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_div", diverge, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_kind", diverge_kind, 0);
    @(negedge clk); reset_n = 1'b1; lb_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
